// File: rtl/led_pkg.sv
// Shared constants for the LED pattern engine: step modes and bounce direction encoding.
package led_pkg;

  localparam logic [1:0] MODE_ROT_L  = 2'b00;
  localparam logic [1:0] MODE_ROT_R  = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/led_pattern_engine_if.sv
// Control/status bundle between a controller (master) and the LED pattern engine (slave).
interface led_pattern_engine_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             en;
  logic [1:0]       mode;
  logic [1:0]       speed;
  logic             step_req;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] data_out;
  logic             dir;
  logic             step_pulse;

  modport master (
    output en, mode, speed, step_req, load, load_value,
    input  data_out, dir, step_pulse
  );

  modport slave (
    input  en, mode, speed, step_req, load, load_value,
    output data_out, dir, step_pulse
  );

endinterface

// File: rtl/led_pattern_engine_tick_prescaler.sv
// Programmable step-tick generator: one tick every (TICK_DIV >> speed) enabled cycles.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned CNT_W    = $clog2(TICK_DIV)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] speed,
  output logic       tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      period;
  logic [CNT_W-1:0] period_m1;

  // >= rather than == so a speed increase mid-count ticks at once instead of wrapping.
  always_comb begin
    period    = 32'(TICK_DIV) >> speed;
    period_m1 = CNT_W'(period - 32'd1);
    tick      = en & (cnt_q >= period_m1);
    cnt_d     = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine: rotate/bounce/hold stepping of a WIDTH-bit pattern with load and manual step.
module led_pattern_engine
  import led_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned CNT_W    = $clog2(TICK_DIV)
) (
  input logic               clk,
  input logic               rst,
  led_pattern_engine_if.slave bus
);

  logic             tick;
  logic             step_ev;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic             pulse_q, pulse_d;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.en),
    .clr   (bus.load),
    .speed (bus.speed),
    .tick  (tick)
  );

  assign step_ev = (bus.en & tick) | (~bus.en & bus.step_req);

  always_comb begin
    data_d  = data_q;
    dir_d   = dir_q;
    pulse_d = 1'b0;
    if (bus.load) begin
      // A zero load would blank the bank; substitute a single dot.
      data_d = (bus.load_value == '0) ? WIDTH'(1) : bus.load_value;
    end else if (step_ev) begin
      pulse_d = 1'b1;
      unique case (bus.mode)
        MODE_ROT_L: begin
          data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
          dir_d  = DIR_LEFT;
        end
        MODE_ROT_R: begin
          data_d = {data_q[0], data_q[WIDTH-1:1]};
          dir_d  = DIR_RIGHT;
        end
        MODE_BOUNCE: begin
          // Edge check follows the current direction, so it wins when both edges are lit.
          if (dir_q == DIR_LEFT && data_q[WIDTH-1]) begin
            dir_d  = DIR_RIGHT;
            data_d = {1'b0, data_q[WIDTH-1:1]};
          end else if (dir_q == DIR_RIGHT && data_q[0]) begin
            dir_d  = DIR_LEFT;
            data_d = {data_q[WIDTH-2:0], 1'b0};
          end else if (dir_q == DIR_LEFT) begin
            data_d = {data_q[WIDTH-2:0], 1'b0};
          end else begin
            data_d = {1'b0, data_q[WIDTH-1:1]};
          end
        end
        MODE_HOLD: begin
          data_d = data_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= WIDTH'(1);
      dir_q   <= DIR_LEFT;
      pulse_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      dir_q   <= dir_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.dir        = dir_q;
  assign bus.step_pulse = pulse_q;

endmodule
